// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access stage: access-size codes, FSM states,
// access kinds and the store lane/byte-enable helpers.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} mau_state_e;

    typedef enum logic [1:0] {FETCH, READ, WRITE} acc_kind_t;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << lane;
            2'b01:   store_be = 4'b0011 << {lane[1], 1'b0};
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load aligner: picks the byte/halfword lane out of the bus word and sign- or zero-extends it.
module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] ext_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata_word_i[{lane_i, 3'b000} +: 8];
        h = rdata_word_i[{lane_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    ext_o = {{24{b[7]}}, b};
            F3_H:    ext_o = {{16{h[15]}}, h};
            F3_BU:   ext_o = {24'b0, b};
            F3_HU:   ext_o = {16'b0, h};
            default: ext_o = rdata_word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Converts fetch/load/store strobes from the multicycle FSM into a req/gnt/rvalid bus access.
// Optional MISALIGN_TRAP_EN: misaligned H/W/fetch accesses skip the bus and pulse misalign.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned AW             = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acc_fetch,
    input  logic          acc_read,
    input  logic          acc_write,
    input  logic [AW-1:0] adr,
    input  logic [31:0]   wdata,
    input  logic [2:0]    funct3,
    output logic          stall,
    output logic [31:0]   instr,
    output logic [31:0]   rdata,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [31:0]   bus_wdata,
    input  logic          bus_gnt,
    input  logic          bus_rvalid,
    input  logic [31:0]   bus_rdata,
    output logic          bus_err,
    output logic          misalign
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    mau_state_e    state_q, state_d;
    acc_kind_t     kind_q, kind_in;
    logic [1:0]    lane_q;
    logic [2:0]    f3_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    logic [3:0]    be_q;
    logic [31:0]   bwd_q;
    logic [31:0]   instr_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          acc_any, accept, mis_in, expired, timeout, capture;
    logic [31:0]   load_ext;

    assign acc_any = acc_fetch | acc_write | acc_read;
    assign kind_in = acc_fetch ? FETCH : (acc_write ? WRITE : READ);
    assign accept  = (state_q == ST_IDLE) && acc_any && !mis_in;
    assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

`ifdef MISALIGN_TRAP_EN
    logic mis_q;

    always_comb begin
        mis_in = 1'b0;
        if (kind_in == FETCH || funct3[1:0] == 2'b10)
            mis_in = (adr[1:0] != 2'b00);
        else if (funct3[1:0] == 2'b01)
            mis_in = adr[0];
    end

    // Pulse lands in DONE, the one cycle the FSM sees stall low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mis_q <= 1'b0;
        else      mis_q <= (state_q == ST_IDLE) && acc_any && mis_in;
    end

    assign misalign = mis_q;
`else
    assign mis_in   = 1'b0;
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bus_req = 1'b0;
        timeout = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (acc_any) begin
                    stall   = 1'b1;
                    state_d = mis_in ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (bus_gnt) begin
                    state_d = (kind_q == WRITE) ? ST_DONE : ST_WAIT;
                end else if (expired) begin
                    state_d = ST_DONE;
                    timeout = 1'b1;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (bus_rvalid) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else if (expired) begin
                    state_d = ST_DONE;
                    timeout = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    mem_load_ext u_load_ext (
        .rdata_word_i (bus_rdata),
        .lane_i       (lane_q),
        .funct3_i     (f3_q),
        .ext_o        (load_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            kind_q  <= FETCH;
            lane_q  <= 2'b00;
            f3_q    <= 3'b000;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            bwd_q   <= '0;
            instr_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= timeout;
            if (accept) begin
                kind_q <= kind_in;
                lane_q <= adr[1:0];
                f3_q   <= funct3;
                addr_q <= {adr[AW-1:2], 2'b00};
                be_q   <= (kind_in == WRITE) ? store_be(funct3, adr[1:0]) : 4'b1111;
                bwd_q  <= store_data(funct3, wdata);
            end
            if (capture) begin
                if (kind_q == FETCH) instr_q <= bus_rdata;
                else                 rdata_q <= load_ext;
            end
        end
    end

    assign bus_we    = bus_req && (kind_q == WRITE);
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = bwd_q;
    assign instr     = instr_q;
    assign rdata     = rdata_q;
    assign bus_err   = err_q;

endmodule
